clkdiv_bank: RTL and testbench
==============================

CLKDIV_BANK -- requirements
Module: clkdiv_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent divider channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 16, width of the counter, divisor and high-time fields.
REQ-003 SHALL have parameter RESET_DIV, default 10, divisor loaded into every channel at reset (>=2).
REQ-004 SHALL have port clock_in  input  1  source clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port cfg_valid  input  1  configuration request.
REQ-007 SHALL have port cfg_ready  output  1  channel selected by cfg_ch can accept a configuration.
REQ-008 SHALL have port cfg_ch  input  $clog2(NUM_CH) (min 1)  target channel.
REQ-009 SHALL have port cfg_div  input  CNT_W  new period in clock_in cycles.
REQ-010 SHALL have port cfg_high  input  CNT_W  new high time in clock_in cycles.
REQ-011 SHALL have port sync  input  1  phase-align pulse for all channels.
REQ-012 SHALL have port clk_out  output  NUM_CH  registered divided outputs.
REQ-013 SHALL have port tick  output  NUM_CH  one-cycle pulse at each period start.
REQ-014 SHALL have port pending  output  NUM_CH  channel holds an accepted, not-yet-applied configuration.

Function
REQ-015 Per channel, active registers div_a, high_a, counter cnt (CNT_W bits), shadow registers div_p, high_p, flag pend.
REQ-016 Each edge with div_a>=1: clk_out <= (cnt < high_a); tick <= (cnt==0); cnt <= (cnt >= div_a-1) ? 0 : cnt+1.
REQ-017 Resulting period = div_a cycles, high for min(high_a, div_a) cycles; clk_out/tick lag cnt by one cycle.
REQ-018 high_a==0: clk_out constant 0; high_a>=div_a: constant 1; tick unaffected.
REQ-019 div_a==1: clk_out constant 1 if high_a>=1, tick asserted every cycle.
REQ-020 div_a==0: channel IDLE; clk_out 0, tick 0, cnt held 0.
REQ-021 cfg_ready = !pend[cfg_ch] combinationally; accept when cfg_valid && cfg_ready: div_p<=cfg_div, high_p<=cfg_high, pend<=1.
REQ-022 Channel states: IDLE (div_a==0), RUN (div_a>0, pend=0), RUN_PEND (div_a>0, pend=1).
REQ-023 RUN_PEND -> apply at the edge where cnt>=div_a-1: div_a<=div_p, high_a<=high_p, cnt<=0, pend<=0; no runt pulse produced.
REQ-024 IDLE with pend=1 -> apply on the next edge; cnt<=0; first tick one cycle later.
REQ-025 Acceptance on the same edge as a wrap stores into shadow only; applied at the following wrap.
REQ-026 Acceptance on channel A does not affect any other channel; one acceptance per cycle maximum.
REQ-027 sync=1: every channel sets cnt<=0 and applies any pending configuration on that edge; sync overrides a coincident wrap.
REQ-028 cfg_ch >= NUM_CH: cfg_ready=1, request consumed and discarded.

Reset
REQ-029 rst=1 at an edge: cnt=0, div_a=div_p=RESET_DIV, high_a=high_p=RESET_DIV/2, pend=0, clk_out=0, tick=0.
REQ-030 rst overrides cfg acceptance and sync; reset mid-period discards pending configurations; first tick one cycle after rst deasserts.

Structure
REQ-031 Package clkdiv_pkg SHALL hold CNT_W default, RESET_DIV default and the channel-state enumeration.
REQ-032 One sub-module clkdiv_channel SHALL implement REQ-015..REQ-027 for one channel; clkdiv_bank instantiates NUM_CH copies plus cfg decode.

Verification
REQ-033 Reset, no config, 40 cycles -> every clk_out period 10, high 5, tick every 10 cycles.
REQ-034 Ch1 cfg div=4 high=1 at cnt=3 of 10 -> pending[1]=1 until wrap; then period 4, high 1, no pulse shorter than 1 or longer than 5.
REQ-035 Second cfg to ch1 while pending -> cfg_ready=0, shadow unchanged; cfg to ch2 same cycle accepted.
REQ-036 Ch0 div=0 then div=3 high=3 -> clk_out 0 while idle, then constant 1, tick every 3 cycles.
REQ-037 Ch0 div=6, ch2 div=9 free-running, sync pulse -> both tick on the cycle after sync, pending applied.
REQ-038 rst asserted with pending on ch3 -> pending cleared, ch3 resumes period 10, high 5.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// rtl/clkdiv_pkg.sv - shared defaults and channel-state type for the clock divider bank
package clkdiv_pkg;

  localparam int CNT_W_DEF     = 16;
  localparam int RESET_DIV_DEF = 10;

  typedef enum logic [1:0] {
    CH_IDLE     = 2'd0,
    CH_RUN      = 2'd1,
    CH_RUN_PEND = 2'd2
  } ch_state_e;

endpackage

// File: rtl/clkdiv_channel.sv
// rtl/clkdiv_channel.sv - one divider channel with shadowed config applied at period boundaries
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int RESET_DIV = RESET_DIV_DEF
) (
  input  logic             clock_in,
  input  logic             rst,
  input  logic             cfg_we_i,
  input  logic [CNT_W-1:0] cfg_div_i,
  input  logic [CNT_W-1:0] cfg_high_i,
  input  logic             sync_i,
  output logic             clk_out_o,
  output logic             tick_o,
  output logic             pending_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_a_q, div_a_d, high_a_q, high_a_d;
  logic [CNT_W-1:0] div_p_q, div_p_d, high_p_q, high_p_d;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d, tick_q, tick_d;
  logic             wrap;
  ch_state_e        state;

  always_comb begin
    cnt_d    = cnt_q;
    div_a_d  = div_a_q;
    high_a_d = high_a_q;
    div_p_d  = div_p_q;
    high_p_d = high_p_q;
    pend_d   = pend_q;

    if (div_a_q == '0)  state = CH_IDLE;
    else if (pend_q)    state = CH_RUN_PEND;
    else                state = CH_RUN;

    wrap   = (state != CH_IDLE) && (cnt_q >= div_a_q - CNT_W'(1));
    clk_d  = (state != CH_IDLE) && (cnt_q < high_a_q);
    tick_d = (state != CH_IDLE) && (cnt_q == '0);

    // Shadow is only swapped in on a period boundary so no runt pulse escapes.
    case (state)
      CH_IDLE: begin
        cnt_d = '0;
        if (pend_q) begin
          div_a_d  = div_p_q;
          high_a_d = high_p_q;
          pend_d   = 1'b0;
        end
      end
      CH_RUN: begin
        cnt_d = (sync_i || wrap) ? '0 : cnt_q + CNT_W'(1);
      end
      CH_RUN_PEND: begin
        if (sync_i || wrap) begin
          cnt_d    = '0;
          div_a_d  = div_p_q;
          high_a_d = high_p_q;
          pend_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: cnt_d = '0;
    endcase

    if (cfg_we_i && !pend_q) begin
      div_p_d  = cfg_div_i;
      high_p_d = cfg_high_i;
      pend_d   = 1'b1;
    end
  end

  always_ff @(posedge clock_in) begin
    if (rst) begin
      cnt_q    <= '0;
      div_a_q  <= CNT_W'(RESET_DIV);
      high_a_q <= CNT_W'(RESET_DIV / 2);
      div_p_q  <= CNT_W'(RESET_DIV);
      high_p_q <= CNT_W'(RESET_DIV / 2);
      pend_q   <= 1'b0;
      clk_q    <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      div_a_q  <= div_a_d;
      high_a_q <= high_a_d;
      div_p_q  <= div_p_d;
      high_p_q <= high_p_d;
      pend_q   <= pend_d;
      clk_q    <= clk_d;
      tick_q   <= tick_d;
    end
  end

  assign clk_out_o = clk_q;
  assign tick_o    = tick_q;
  assign pending_o = pend_q;

endmodule

// File: rtl/clkdiv_bank.sv
// rtl/clkdiv_bank.sv - bank of independent clock dividers with per-channel config decode
module clkdiv_bank
  import clkdiv_pkg::*;
#(
  parameter int  NUM_CH    = 4,
  parameter int  CNT_W     = CNT_W_DEF,
  parameter int  RESET_DIV = RESET_DIV_DEF,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock_in,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [CNT_W-1:0]  cfg_high,
  input  logic              sync,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pending
);

  logic [NUM_CH-1:0] ch_sel;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ch_sel[i] = (cfg_ch == CH_W'(i));

    clkdiv_channel #(
      .CNT_W     (CNT_W),
      .RESET_DIV (RESET_DIV)
    ) u_ch (
      .clock_in   (clock_in),
      .rst        (rst),
      .cfg_we_i   (cfg_valid && ch_sel[i]),
      .cfg_div_i  (cfg_div),
      .cfg_high_i (cfg_high),
      .sync_i     (sync),
      .clk_out_o  (clk_out[i]),
      .tick_o     (tick[i]),
      .pending_o  (pending[i])
    );
  end

  // An out-of-range channel matches no select line, so the request is swallowed.
  assign cfg_ready = ~|(ch_sel & pending);

endmodule

// File: tb/tb_clkdiv_bank.sv
// tb/tb_clkdiv_bank.sv - randomized and directed bench for clkdiv_bank against a period-level model
module tb_clkdiv_bank;

  localparam int NCH   = 5;
  localparam int CNT_W = 16;
  localparam int CH_W  = 3;

  logic              clock_in = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [CNT_W-1:0]  cfg_div = '0;
  logic [CNT_W-1:0]  cfg_high = '0;
  logic              sync = 1'b0;
  logic [NCH-1:0]    clk_out, tick, pending;

  clkdiv_bank #(.NUM_CH(NCH), .CNT_W(CNT_W), .RESET_DIV(10)) dut (
    .clock_in (clock_in),
    .rst      (rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_high (cfg_high),
    .sync     (sync),
    .clk_out  (clk_out),
    .tick     (tick),
    .pending  (pending)
  );

  always #5 clock_in = ~clock_in;

  int n_chk = 0;
  int n_err = 0;

  // Reference: each channel is a phase within its current period plus a waiting config.
  int             m_div[NCH], m_high[NCH], m_ph[NCH], m_ndiv[NCH], m_nhigh[NCH];
  logic [NCH-1:0] m_pend, m_clk, m_tick;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic exp_ready();
    if (int'(cfg_ch) >= NCH) return 1'b1;
    return !m_pend[cfg_ch];
  endfunction

  task automatic model_edge();
    for (int c = 0; c < NCH; c++) begin
      if (rst) begin
        m_div[c] = 10; m_high[c] = 5; m_ph[c] = 0;
        m_ndiv[c] = 10; m_nhigh[c] = 5;
        m_pend[c] = 1'b0; m_clk[c] = 1'b0; m_tick[c] = 1'b0;
      end else begin
        logic take, boundary;
        take        = cfg_valid && (int'(cfg_ch) == c) && !m_pend[c];
        m_clk[c]    = (m_div[c] > 0) && (m_ph[c] < m_high[c]);
        m_tick[c]   = (m_div[c] > 0) && (m_ph[c] == 0);
        boundary    = (m_div[c] == 0) || (m_ph[c] == m_div[c] - 1) || sync;
        if (boundary) begin
          m_ph[c] = 0;
          if (m_pend[c]) begin
            m_div[c] = m_ndiv[c]; m_high[c] = m_nhigh[c]; m_pend[c] = 1'b0;
          end
        end else begin
          m_ph[c]++;
        end
        if (take) begin
          m_ndiv[c] = int'(cfg_div); m_nhigh[c] = int'(cfg_high); m_pend[c] = 1'b1;
        end
      end
    end
  endtask

  task automatic step();
    #1;
    check("cfg_ready", {31'd0, cfg_ready}, {31'd0, exp_ready()});
    @(posedge clock_in);
    model_edge();
    #1;
    check("clk_out", 32'(clk_out), 32'(m_clk));
    check("tick",    32'(tick),    32'(m_tick));
    check("pending", 32'(pending), 32'(m_pend));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic cfg(input int ch, input int dv, input int hi);
    cfg_valid = 1'b1; cfg_ch = CH_W'(ch); cfg_div = CNT_W'(dv); cfg_high = CNT_W'(hi);
    step();
    cfg_valid = 1'b0;
  endtask

  initial begin
    @(negedge clock_in);
    run(2);
    check("rst_clk_out", 32'(clk_out), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    rst = 1'b0;
    run(40);

    for (int k = 0; k < 20 && m_ph[1] != 3; k++) step();
    check("ch1_phase3", 32'(m_ph[1]), 32'd3);
    cfg(1, 4, 1);
    check("ch1_pending", {31'd0, pending[1]}, 32'd1);
    run(20);

    cfg(1, 7, 2);
    cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_div = 16'd5; cfg_high = 16'd5;
    #1;
    check("ch1_busy_ready", {31'd0, cfg_ready}, 32'd0);
    step();
    cfg(2, 6, 3);
    run(20);

    cfg(0, 0, 0);
    run(25);
    cfg(0, 3, 3);
    run(15);

    cfg(0, 6, 2);
    run(8);
    cfg(2, 9, 4);
    run(12);
    cfg(0, 5, 2);
    sync = 1'b1;
    step();
    sync = 1'b0;
    step();
    check("sync_tick", 32'(tick & 5'b00101), 32'h5);
    run(20);

    run(4);
    cfg(3, 2, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_drops_pend3", {31'd0, pending[3]}, 32'd0);
    run(25);

    for (int k = 0; k < 1500; k++) begin
      cfg_valid = ($urandom % 3) == 0;
      cfg_ch    = CH_W'($urandom % 8);
      cfg_div   = CNT_W'($urandom % 13);
      cfg_high  = CNT_W'($urandom % 15);
      sync      = ($urandom % 40) == 0;
      rst       = ($urandom % 250) == 0;
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
